cla_addsub_pipe: RTL and testbench

- Parameterised, pipelined carry-lookahead adder/subtractor for the datapath.
- The carry chain is built from 4-bit lookahead groups with group propagate/generate, and is cut into STAGES register stages.
- Operands enter and results leave through valid/ready handshakes, with full backpressure.
- Result flags (carry, signed overflow, zero, negative) are produced for downstream ALU and branch logic.

---
 rtl/cla_addsub_pipe.sv | 189 ++++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead adder/subtractor with
// valid/ready handshakes and carry/overflow/zero/negative flags.
// The carry chain is built from 4-bit lookahead groups and split evenly
// over STAGES register stages; each stage resolves GROUPS_PER_STAGE groups.
// Optional feature macro: CLA_SATURATE_EN adds a sat_mode input that clamps
// the sum to the signed extreme on overflow.
module cla_addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
`ifdef CLA_SATURATE_EN
   input  logic             sat_mode,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int NGROUPS          = WIDTH / 4;
   localparam int GROUPS_PER_STAGE = NGROUPS / STAGES;
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // 4-bit lookahead group: returns {carry into bit 3, group carry out, sum[3:0]}.
   // Group carry out uses block terms G/P so the ripple never crosses a group.
   function automatic logic [5:0] cla4(input logic [3:0] x_a,
                                       input logic [3:0] x_b,
                                       input logic       c0);
      logic [3:0] g_v;
      logic [3:0] p_v;
      logic [3:0] x_v;
      logic       c1_v;
      logic       c2_v;
      logic       c3_v;
      logic       gg_v;
      logic       pp_v;
      logic       c4_v;
      g_v  = x_a & x_b;
      p_v  = x_a | x_b;
      x_v  = x_a ^ x_b;
      c1_v = g_v[0] | (p_v[0] & c0);
      c2_v = g_v[1] | (p_v[1] & g_v[0]) | (p_v[1] & p_v[0] & c0);
      c3_v = g_v[2] | (p_v[2] & g_v[1]) | (p_v[2] & p_v[1] & g_v[0])
           | (p_v[2] & p_v[1] & p_v[0] & c0);
      gg_v = g_v[3] | (p_v[3] & g_v[2]) | (p_v[3] & p_v[2] & g_v[1])
           | (p_v[3] & p_v[2] & p_v[1] & g_v[0]);
      pp_v = &p_v;
      c4_v = gg_v | (pp_v & c0);
      return {c3_v, c4_v, x_v ^ {c3_v, c2_v, c1_v, c0}};
   endfunction

   // Stage registers: operands still to be processed, completed sum bits,
   // carry into the next unresolved group, valid and saturation mode.
   logic [WIDTH-1:0] a_r   [STAGES];
   logic [WIDTH-1:0] b_r   [STAGES];
   logic [WIDTH-1:0] s_r   [STAGES];
   logic             c_r   [STAGES];
   logic             v_r   [STAGES];
   logic             sat_r [STAGES];
   logic             ovf_r;
   logic             zero_r;
   logic             neg_r;

   // Stage inputs (ports for stage 0, previous register otherwise) and results.
   logic [WIDTH-1:0] ai_s   [STAGES];
   logic [WIDTH-1:0] bi_s   [STAGES];
   logic [WIDTH-1:0] si_s   [STAGES];
   logic             ci_s   [STAGES];
   logic             vi_s   [STAGES];
   logic             sati_s [STAGES];
   logic [WIDTH-1:0] s_s    [STAGES];
   logic             c_s    [STAGES];
   logic [5:0]       grp_s;
   logic             cy_s;
   logic             cmsb_s;
   logic [WIDTH-1:0] sum_s;
   logic             ovf_s;
   logic             zero_s;
   logic             neg_s;
   logic             adv_s;

   // Global advance: the whole pipe moves whenever the output slot is free or draining.
   always_comb begin
      adv_s = !v_r[STAGES-1] || out_ready;
   end

   // Stage input selection; b is inverted and the carry-in chosen before stage 0.
   always_comb begin
      ai_s[0]   = a;
      bi_s[0]   = op ? ~b : b;
      si_s[0]   = {WIDTH{1'b0}};
      ci_s[0]   = op ? 1'b1 : cin;
      vi_s[0]   = in_valid;
`ifdef CLA_SATURATE_EN
      sati_s[0] = sat_mode;
`else
      sati_s[0] = 1'b0;
`endif
      for (int k = 1; k < STAGES; k++) begin
         ai_s[k]   = a_r[k-1];
         bi_s[k]   = b_r[k-1];
         si_s[k]   = s_r[k-1];
         ci_s[k]   = c_r[k-1];
         vi_s[k]   = v_r[k-1];
         sati_s[k] = sat_r[k-1];
      end
   end

   // Per-stage lookahead: resolve this stage's groups, forward low sum bits unchanged.
   always_comb begin
      grp_s  = 6'b000000;
      cy_s   = 1'b0;
      cmsb_s = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         s_s[k] = si_s[k];
         cy_s   = ci_s[k];
         for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
            grp_s = cla4(ai_s[k][(k*GROUPS_PER_STAGE+j)*4 +: 4],
                         bi_s[k][(k*GROUPS_PER_STAGE+j)*4 +: 4], cy_s);
            s_s[k][(k*GROUPS_PER_STAGE+j)*4 +: 4] = grp_s[3:0];
            cy_s   = grp_s[4];
            cmsb_s = ((k*GROUPS_PER_STAGE+j) == (NGROUPS-1)) ? grp_s[5] : cmsb_s;
         end
         c_s[k] = cy_s;
      end
   end

   // Final-stage flags and optional clamp; zero/neg follow the clamped sum.
   always_comb begin
      ovf_s = cmsb_s ^ c_s[STAGES-1];
      if (sati_s[STAGES-1] && ovf_s) begin
         sum_s = ai_s[STAGES-1][WIDTH-1] ? SAT_MIN : SAT_MAX;
      end else begin
         sum_s = s_s[STAGES-1];
      end
      zero_s = (sum_s == {WIDTH{1'b0}});
      neg_s  = sum_s[WIDTH-1];
   end

   // Pipeline registers: synchronous clear, otherwise load together on advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            a_r[k]   <= {WIDTH{1'b0}};
            b_r[k]   <= {WIDTH{1'b0}};
            s_r[k]   <= {WIDTH{1'b0}};
            c_r[k]   <= 1'b0;
            v_r[k]   <= 1'b0;
            sat_r[k] <= 1'b0;
         end
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
         neg_r  <= 1'b0;
      end else if (adv_s) begin
         for (int k = 0; k < STAGES; k++) begin
            a_r[k]   <= ai_s[k];
            b_r[k]   <= bi_s[k];
            s_r[k]   <= (k == STAGES-1) ? sum_s : s_s[k];
            c_r[k]   <= c_s[k];
            v_r[k]   <= vi_s[k];
            sat_r[k] <= sati_s[k];
         end
         ovf_r  <= ovf_s;
         zero_r <= zero_s;
         neg_r  <= neg_s;
      end
   end

   assign in_ready  = adv_s;
   assign out_valid = v_r[STAGES-1];
   assign sum       = s_r[STAGES-1];
   assign cout      = c_r[STAGES-1];
   assign ovf       = ovf_r;
   assign zero      = zero_r;
   assign neg       = neg_r;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (WIDTH=32, STAGES=2): directed
// cases with literal expectations plus randomized traffic checked against
// a plain-arithmetic model through a scoreboard queue.
module tb_cla_addsub_pipe;
   localparam int W  = 32;
   localparam int ST = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          op;
   logic          sat_mode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic          zero;
   logic          neg;

   int total = 0;
   int bad = 0;
   int out_count = 0;

   typedef logic [35:0] res_t;   // {sum, cout, ovf, zero, neg}
   res_t q[$];
   logic prev_stall = 1'b0;

   cla_addsub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .op(op),
`ifdef CLA_SATURATE_EN
      .sat_mode(sat_mode),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
   );

   always #5 clk = ~clk;

   // Reference: whole-word arithmetic with one extra bit for the carry.
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mop, input logic mcin, input logic msat);
      logic [W:0]   full;
      logic [W-1:0] bb;
      logic [W-1:0] r;
      logic         c;
      logic         v;
      bb   = mop ? ~mb : mb;
      full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (mop ? 1'b1 : mcin)};
      r    = full[W-1:0];
      c    = full[W];
      v    = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
`ifdef CLA_SATURATE_EN
      if (msat && v) r = ma[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
      if (msat && 1'b0) r = 32'h0000_0000;
`endif
      return {r, c, v, (r == 32'h0000_0000), r[W-1]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: compare visible results, then record accepted inputs.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
         if (prev_stall) chk("hold_valid", {63'd0, out_valid}, 64'd1);
         if (out_valid) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got sum %h expected no result", sum);
            end else begin
               chk("result", {28'd0, sum, cout, ovf, zero, neg}, {28'd0, q[0]});
               if (out_ready) begin
                  void'(q.pop_front());
                  out_count++;
               end
            end
         end
         if (in_valid && in_ready) q.push_back(model(a, b, op, cin, sat_mode));
         prev_stall = out_valid && !out_ready;
      end
   end

   // One transaction into an idle pipe; checks latency and literal results.
   task automatic run_one(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic top, input logic tcin, input logic tsat,
                          input logic [W-1:0] esum, input logic [3:0] eflags);
      int lat;
      @(posedge clk); #1;
      a = ta; b = tb; op = top; cin = tcin; sat_mode = tsat;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'(ST));
      chk({nm, "_sum"}, {32'd0, sum}, {32'd0, esum});
      chk({nm, "_flags"}, {60'd0, cout, ovf, zero, neg}, {60'd0, eflags});
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      int g;
      logic acc;
      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0;
      sat_mode = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_sum", {32'd0, sum}, 64'd0);
      chk("reset_flags", {60'd0, cout, ovf, zero, neg}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

      // Pin the reference model to hand-computed values.
      chk("model_add", {28'd0, model(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 1'b0)},
          {28'd0, 32'h0001_0000, 4'b0000});
      chk("model_sub_ovf", {28'd0, model(32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b0)},
          {28'd0, 32'h7FFF_FFFF, 4'b1100});
      chk("model_sub_zero", {28'd0, model(32'h5, 32'h5, 1'b1, 1'b1, 1'b0)},
          {28'd0, 32'h0, 4'b1010});

      // Flags are {cout, ovf, zero, neg}.
      run_one("add_boundary", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 4'b0000);
      run_one("sub_zero", 32'h5, 32'h5, 1'b1, 1'b0, 1'b0, 32'h0, 4'b1010);
      run_one("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'b1100);
      run_one("add_cin_wrap", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 4'b1010);
      run_one("sub_ignores_cin", 32'h3, 32'h1, 1'b1, 1'b1, 1'b0, 32'h2, 4'b1000);
      run_one("sub_borrow", 32'h0, 32'h1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b0001);
`ifdef CLA_SATURATE_EN
      run_one("sat_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0100);
      run_one("sat_neg", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 4'b1101);
`else
      run_one("sat_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 4'b0101);
`endif

      // Backpressure: four back-to-back adds, output stalled three cycles.
      out_ready = 1'b0;
      sat_mode = 1'b0;
      n = out_count;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               a = 32'(i + 1); b = 32'(i * 256); op = 1'b0; cin = 1'b0;
               in_valid = 1'b1;
               g = 0;
               do begin
                  @(negedge clk);
                  acc = in_ready;
                  @(posedge clk); #1;
                  g++;
               end while (!acc && g < 20);
            end
            in_valid = 1'b0;
         end
         begin
            int w;
            w = 0;
            while (!out_valid && w < 20) begin
               @(posedge clk); #1;
               w++;
            end
            chk("bp_first_valid", {63'd0, out_valid}, 64'd1);
            for (int s = 0; s < 3; s++) begin
               chk("bp_stall_in_ready", {63'd0, in_ready}, 64'd0);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      g = 0;
      while (out_count < n + 4 && g < 30) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("bp_count", 64'(out_count - n), 64'd4);

      // Reset with two results in flight.
      out_ready = 1'b0;
      a = 32'd10; b = 32'd20; op = 1'b0; cin = 1'b0; in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      n = out_count;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midreset_sum", {32'd0, sum}, 64'd0);
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midreset_no_stale", 64'(out_count - n), 64'd0);

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         a         = pick();
         b         = pick();
         op        = 1'($urandom_range(0, 1));
         cin       = 1'($urandom_range(0, 1));
         sat_mode  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      g = 0;
      while (q.size() != 0 && g < 20) begin
         @(posedge clk); #1;
         g++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
